aurora_link_reset_ctrl: RTL and testbench
=========================================

// Module: aurora_link_reset_ctrl
// PURPOSE
//  Power-on and recovery reset sequencer for the 4-lane Aurora 64B66B core inside krnl_aurora.
//  Runs in the init_clk domain and drives the core's reset_pb and pma_init inputs in the required order.
//  Watches channel_up and hard_err, both synchronised from the user_clk domain.
//  Re-runs the full sequence on link-up timeout, link loss, hard error or software request.
// PARAMETERS
//  HOLD_CYCLES       27'h7ff_ff00  init_clk cycles both resets stay asserted (>1 s at 50/100 MHz)
//  PMA_LEAD_CYCLES   255           cycles pma_init is released before reset_pb
//  LINK_TIMEOUT      50_000_000    cycles to wait for channel_up after release before retrying
//  CNT_W             27            shared counter width; must hold max(HOLD_CYCLES, LINK_TIMEOUT)
// PORTS
//  init_clk       in   1  free-running init clock (50 MHz nominal)
//  ap_rst_n_i     in   1  reset; asynchronous, active-low (already synchronised to init_clk upstream)
//  channel_up_u   in   1  Aurora channel_up, user_clk domain; async to this block
//  hard_err_u     in   1  Aurora hard_err, user_clk domain; async to this block
//  reinit_req     in   1  init_clk single-cycle pulse requesting a full re-initialisation
//  reset_pb       out  1  to Aurora reset_pb, active-high
//  pma_init       out  1  to Aurora pma_init, active-high
//  link_ready     out  1  high while in LINK_UP
//  seq_state      out  2  current state encoding (for status readback)
//  retry_cnt      out  8  re-init count; present only with AURORA_RST_RETRY_CNT_EN
// BEHAVIOUR
//  Reset values: reset_pb=1, pma_init=1, link_ready=0, seq_state=RESET_HOLD, cnt=0, retry_cnt=0.
//  channel_up_u and hard_err_u each pass a 2-flop synchroniser. The FSM sees them 2 cycles late.
//  FSM states and encodings:
//   RESET_HOLD(0)
//    - reset_pb=1, pma_init=1; cnt counts 0..HOLD_CYCLES-1.
//    - At cnt==HOLD_CYCLES-1 go to PMA_RELEASE and clear cnt.
//    - reinit_req is ignored in this state.
//   PMA_RELEASE(1)
//    - pma_init=0, reset_pb=1; cnt counts 0..PMA_LEAD_CYCLES-1, then go to WAIT_LINK and clear cnt.
//   WAIT_LINK(2)
//    - Both resets 0.
//    - Synced channel_up=1 -> LINK_UP.
//    - cnt==LINK_TIMEOUT-1 -> RESET_HOLD (retry).
//   LINK_UP(3)
//    - Both resets 0; link_ready=1.
//    - Synced channel_up=0 or synced hard_err=1 -> RESET_HOLD (retry).
//  reinit_req in PMA_RELEASE, WAIT_LINK or LINK_UP -> RESET_HOLD next cycle.
//  Priority in the same cycle: reinit_req > hard_err > timeout > channel_up.
//  Every entry to RESET_HOLD clears cnt and reasserts reset_pb and pma_init on the same edge.
//  Outputs are registered and decoded from the next state:
//   - pma_init falls exactly HOLD_CYCLES cycles after the first init_clk edge following reset release.
//   - reset_pb falls PMA_LEAD_CYCLES cycles after pma_init falls.
//   - link_ready rises 3 cycles after a channel_up_u rise (2 sync cycles + 1 state register).
//  cnt saturates and never wraps; only the terminal-count comparisons advance the FSM.
//  hard_err pulses narrower than 2 init_clk periods may be missed; the channel_up drop covers that case.
//  ap_rst_n_i assertion mid-sequence forces the reset values immediately (asynchronous).
// CONFIGURATION
//  Macro AURORA_RST_RETRY_CNT_EN.
//  Defined:
//   - Adds the retry_cnt port and register.
//   - +1 on each RESET_HOLD entry caused by timeout, link loss, hard_err or reinit_req.
//   - Saturates at 8'hFF; cleared only by ap_rst_n_i.
//  Undefined: no retry_cnt port or logic; all other behaviour identical.
// STRUCTURE
//  Shared package aurora_ctrl_pkg:
//   - state typedef/localparams RESET_HOLD=2'd0, PMA_RELEASE=2'd1, WAIT_LINK=2'd2, LINK_UP=2'd3.
//   - Default timing constants.
//  Sub-module aurora_sync_bit: 2-flop synchroniser with ASYNC_REG attribute, instantiated twice.
//  FSM, counter and output registers live in the top module.
// TESTING (bench params HOLD_CYCLES=16, PMA_LEAD_CYCLES=4, LINK_TIMEOUT=32)
//  1. Release ap_rst_n_i, channel_up_u=0.
//     -> pma_init falls at cycle 16, reset_pb at cycle 20.
//     -> Timeout at cycle 52 reasserts both; retry_cnt=1.
//  2. Raise channel_up_u 10 cycles into WAIT_LINK.
//     -> link_ready=1 exactly 3 cycles later; seq_state=3; no further retry.
//  3. In LINK_UP, drop channel_up_u.
//     -> 3 cycles later reset_pb=pma_init=1, link_ready=0; full 16/4 sequence repeats.
//  4. In LINK_UP, pulse hard_err_u for 3 cycles with channel_up_u held high.
//     -> RESET_HOLD entered; retry_cnt increments by exactly 1.
//  5. Assert reinit_req together with channel_up rising in WAIT_LINK.
//     -> RESET_HOLD wins; reinit_req during RESET_HOLD leaves cnt unaffected.
//  6. Assert ap_rst_n_i mid-PMA_RELEASE.
//     -> All outputs take reset values without waiting for a clock edge; 300 forced retries leave retry_cnt=8'hFF.

Source files
------------

// File: rtl/aurora_link_reset_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : aurora_ctrl_pkg
//  Purpose   : Shared state encoding and default timing constants for the
//              Aurora 64B66B link reset sequencer.
//  Revision  : 1.0 - initial release
// ============================================================================
package aurora_ctrl_pkg;

  // Sequencer states; encodings are visible on the seq_state status port.
  typedef enum logic [1:0] {
    RESET_HOLD  = 2'd0,
    PMA_RELEASE = 2'd1,
    WAIT_LINK   = 2'd2,
    LINK_UP     = 2'd3
  } link_state_e;

  // Both resets held for >1 s at 50/100 MHz init_clk.
  localparam int unsigned DEF_HOLD_CYCLES     = 32'h07ff_ff00;
  // pma_init must be released this many cycles ahead of reset_pb.
  localparam int unsigned DEF_PMA_LEAD_CYCLES = 255;
  // Time allowed for channel_up after both resets are released.
  localparam int unsigned DEF_LINK_TIMEOUT    = 50_000_000;
  // Shared counter width; covers the larger of hold and timeout.
  localparam int unsigned DEF_CNT_W           = 27;

endpackage : aurora_ctrl_pkg
`default_nettype wire

// File: rtl/aurora_link_reset_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface : aurora_link_reset_ctrl_if
//  Purpose   : Bundles the Aurora core status inputs, the re-init request and
//              the reset/status outputs of the link reset sequencer.
//              Macro AURORA_RST_RETRY_CNT_EN adds the retry_cnt status field.
//  Revision  : 1.0 - initial release
// ============================================================================
interface aurora_link_reset_ctrl_if;

  logic       channel_up_u;
  logic       hard_err_u;
  logic       reinit_req;
  logic       reset_pb;
  logic       pma_init;
  logic       link_ready;
  logic [1:0] seq_state;
`ifdef AURORA_RST_RETRY_CNT_EN
  logic [7:0] retry_cnt;
`endif

`ifdef AURORA_RST_RETRY_CNT_EN
  // Sequencer side: drives resets and status.
  modport master (
    input  channel_up_u, hard_err_u, reinit_req,
    output reset_pb, pma_init, link_ready, seq_state, retry_cnt
  );
  // Core / host side: supplies status and request, observes resets.
  modport slave (
    output channel_up_u, hard_err_u, reinit_req,
    input  reset_pb, pma_init, link_ready, seq_state, retry_cnt
  );
`else
  // Sequencer side: drives resets and status.
  modport master (
    input  channel_up_u, hard_err_u, reinit_req,
    output reset_pb, pma_init, link_ready, seq_state
  );
  // Core / host side: supplies status and request, observes resets.
  modport slave (
    output channel_up_u, hard_err_u, reinit_req,
    input  reset_pb, pma_init, link_ready, seq_state
  );
`endif

endinterface : aurora_link_reset_ctrl_if
`default_nettype wire

// File: rtl/aurora_link_reset_ctrl_sync_bit.sv
`default_nettype none
// ============================================================================
//  Module    : aurora_sync_bit
//  Purpose   : Two-flop synchroniser bringing a single user_clk-domain level
//              into the init_clk domain. Clears to 0 on reset.
//  Revision  : 1.0 - initial release
// ============================================================================
module aurora_sync_bit (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic d,
  output logic      q
);

  (* ASYNC_REG = "TRUE" *) logic [1:0] sync_ff;

  // Shift the asynchronous level through two metastability-settling stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= 2'b00;
    end else begin
      sync_ff <= {sync_ff[0], d};
    end
  end

  assign q = sync_ff[1];

endmodule : aurora_sync_bit
`default_nettype wire

// File: rtl/aurora_link_reset_ctrl.sv
`default_nettype none
// ============================================================================
//  Module    : aurora_link_reset_ctrl
//  Purpose   : Power-on / recovery reset sequencer for the 4-lane Aurora
//              64B66B core. Holds pma_init and reset_pb, releases pma_init
//              first, then reset_pb, waits for channel_up and restarts the
//              whole sequence on timeout, link loss, hard error or request.
//              Macro AURORA_RST_RETRY_CNT_EN adds a saturating retry counter.
//  Revision  : 1.0 - initial release
// ============================================================================
module aurora_link_reset_ctrl
  import aurora_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned PMA_LEAD_CYCLES = DEF_PMA_LEAD_CYCLES,
  parameter int unsigned LINK_TIMEOUT    = DEF_LINK_TIMEOUT,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  wire logic               init_clk,
  input  wire logic               ap_rst_n_i,
  aurora_link_reset_ctrl_if.master link
);

  // Terminal counts, sized to the counter so comparisons stay width-matched.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] PMA_LAST  = CNT_W'(PMA_LEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LINK_LAST = CNT_W'(LINK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  link_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             reset_pb_q, pma_init_q, link_ready_q;
  logic             channel_up_s, hard_err_s;
  logic             retry_hit;

  aurora_sync_bit u_sync_channel_up (
    .clk   (init_clk),
    .rst_n (ap_rst_n_i),
    .d     (link.channel_up_u),
    .q     (channel_up_s)
  );

  aurora_sync_bit u_sync_hard_err (
    .clk   (init_clk),
    .rst_n (ap_rst_n_i),
    .d     (link.hard_err_u),
    .q     (hard_err_s)
  );

  // Next-state and counter update; reinit > hard_err > timeout > channel_up.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    unique case (state)
      RESET_HOLD: begin
        // reinit_req is deliberately ignored while the resets are held.
        if (cnt == HOLD_LAST) begin
          state_nxt = PMA_RELEASE;
          cnt_nxt   = '0;
        end
      end
      PMA_RELEASE: begin
        if (link.reinit_req) begin
          state_nxt = RESET_HOLD;
          cnt_nxt   = '0;
        end else if (cnt == PMA_LAST) begin
          state_nxt = WAIT_LINK;
          cnt_nxt   = '0;
        end
      end
      WAIT_LINK: begin
        if (link.reinit_req || hard_err_s || (cnt == LINK_LAST)) begin
          state_nxt = RESET_HOLD;
          cnt_nxt   = '0;
        end else if (channel_up_s) begin
          state_nxt = LINK_UP;
          cnt_nxt   = '0;
        end
      end
      LINK_UP: begin
        // Counter is unused while the link is up; keep it parked at zero.
        cnt_nxt = '0;
        if (link.reinit_req || hard_err_s || !channel_up_s) begin
          state_nxt = RESET_HOLD;
        end
      end
      default: begin
        state_nxt = RESET_HOLD;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Any return to RESET_HOLD from a running state is a retry.
  assign retry_hit = (state != RESET_HOLD) && (state_nxt == RESET_HOLD);

  // State, counter and outputs registered together; outputs decode next state.
  always_ff @(posedge init_clk or negedge ap_rst_n_i) begin
    if (!ap_rst_n_i) begin
      state        <= RESET_HOLD;
      cnt          <= '0;
      reset_pb_q   <= 1'b1;
      pma_init_q   <= 1'b1;
      link_ready_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      reset_pb_q   <= (state_nxt == RESET_HOLD) || (state_nxt == PMA_RELEASE);
      pma_init_q   <= (state_nxt == RESET_HOLD);
      link_ready_q <= (state_nxt == LINK_UP);
    end
  end

  assign link.reset_pb   = reset_pb_q;
  assign link.pma_init   = pma_init_q;
  assign link.link_ready = link_ready_q;
  assign link.seq_state  = state;

`ifdef AURORA_RST_RETRY_CNT_EN
  logic [7:0] retry_cnt_q;

  // Count re-initialisations, saturating so a flapping link stays visible.
  always_ff @(posedge init_clk or negedge ap_rst_n_i) begin
    if (!ap_rst_n_i) begin
      retry_cnt_q <= 8'h00;
    end else if (retry_hit && (retry_cnt_q != 8'hFF)) begin
      retry_cnt_q <= retry_cnt_q + 8'h01;
    end
  end

  assign link.retry_cnt = retry_cnt_q;
`else
  // Without the retry counter the retry strobe has no consumer.
  logic unused_retry;
  assign unused_retry = retry_hit;
`endif

endmodule : aurora_link_reset_ctrl
`default_nettype wire

// File: tb/tb_aurora_link_reset_ctrl.sv
`default_nettype none
// ============================================================================
//  Module    : tb_aurora_link_reset_ctrl
//  Purpose   : Directed self-checking bench for aurora_link_reset_ctrl with
//              HOLD_CYCLES=16, PMA_LEAD_CYCLES=4, LINK_TIMEOUT=32.
//              Retry counter checks are active with AURORA_RST_RETRY_CNT_EN.
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_aurora_link_reset_ctrl;

  logic init_clk;
  logic ap_rst_n_i;
  int   checks;
  int   passed;

  aurora_link_reset_ctrl_if link_if ();

  aurora_link_reset_ctrl #(
    .HOLD_CYCLES     (16),
    .PMA_LEAD_CYCLES (4),
    .LINK_TIMEOUT    (32),
    .CNT_W           (27)
  ) dut (
    .init_clk   (init_clk),
    .ap_rst_n_i (ap_rst_n_i),
    .link       (link_if.master)
  );

  // 100 MHz-style clock; period 10.
  initial begin
    init_clk = 1'b0;
    forever #5 init_clk = ~init_clk;
  end

  // Advance one active edge and settle just past it.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge init_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Snapshot of all reset/status outputs.
  task automatic chk_out(input string tag, input logic rpb, input logic pma,
                         input logic rdy, input logic [1:0] st);
    chk({tag, ".reset_pb"},   {31'd0, link_if.reset_pb},   {31'd0, rpb});
    chk({tag, ".pma_init"},   {31'd0, link_if.pma_init},   {31'd0, pma});
    chk({tag, ".link_ready"}, {31'd0, link_if.link_ready}, {31'd0, rdy});
    chk({tag, ".seq_state"},  {30'd0, link_if.seq_state},  {30'd0, st});
  endtask

  task automatic chk_retry(input string tag, input logic [7:0] exp);
`ifdef AURORA_RST_RETRY_CNT_EN
    chk({tag, ".retry_cnt"}, {24'd0, link_if.retry_cnt}, {24'd0, exp});
`else
    if (exp === 8'hxx) $display("unreachable");
`endif
  endtask

  initial begin
    checks = 0;
    passed = 0;
    ap_rst_n_i           = 1'b0;
    link_if.channel_up_u = 1'b0;
    link_if.hard_err_u   = 1'b0;
    link_if.reinit_req   = 1'b0;

    // Reset values.
    step(2);
    chk_out("reset", 1'b1, 1'b1, 1'b0, 2'd0);
    chk_retry("reset", 8'd0);

    // 1. Power-on sequence and timeout; edge 1 is the first after release.
    ap_rst_n_i = 1'b1;
    step(15);
    chk_out("t1.e15", 1'b1, 1'b1, 1'b0, 2'd0);
    step(1);
    chk_out("t1.e16", 1'b1, 1'b0, 1'b0, 2'd1);
    step(3);
    chk_out("t1.e19", 1'b1, 1'b0, 1'b0, 2'd1);
    step(1);
    chk_out("t1.e20", 1'b0, 1'b0, 1'b0, 2'd2);
    step(31);
    chk_out("t1.e51", 1'b0, 1'b0, 1'b0, 2'd2);
    step(1);
    chk_out("t1.e52", 1'b1, 1'b1, 1'b0, 2'd0);
    chk_retry("t1", 8'd1);

    // 2. Sequence repeats; channel_up rises 10 cycles into WAIT_LINK.
    step(16);
    chk_out("t2.pma", 1'b1, 1'b0, 1'b0, 2'd1);
    step(4);
    chk_out("t2.wait", 1'b0, 1'b0, 1'b0, 2'd2);
    step(10);
    link_if.channel_up_u = 1'b1;
    step(2);
    chk_out("t2.up+2", 1'b0, 1'b0, 1'b0, 2'd2);
    step(1);
    chk_out("t2.up+3", 1'b0, 1'b0, 1'b1, 2'd3);
    step(30);
    chk_out("t2.hold", 1'b0, 1'b0, 1'b1, 2'd3);
    chk_retry("t2", 8'd1);

    // 3. Link loss.
    link_if.channel_up_u = 1'b0;
    step(2);
    chk_out("t3.dn+2", 1'b0, 1'b0, 1'b1, 2'd3);
    step(1);
    chk_out("t3.dn+3", 1'b1, 1'b1, 1'b0, 2'd0);
    chk_retry("t3", 8'd2);
    step(15);
    chk_out("t3.e15", 1'b1, 1'b1, 1'b0, 2'd0);
    step(1);
    chk_out("t3.e16", 1'b1, 1'b0, 1'b0, 2'd1);
    step(4);
    chk_out("t3.e20", 1'b0, 1'b0, 1'b0, 2'd2);
    link_if.channel_up_u = 1'b1;
    step(3);
    chk_out("t3.relink", 1'b0, 1'b0, 1'b1, 2'd3);

    // 4. Hard error pulse of 3 cycles with channel_up still high.
    link_if.hard_err_u = 1'b1;
    step(2);
    chk_out("t4.he+2", 1'b0, 1'b0, 1'b1, 2'd3);
    step(1);
    link_if.hard_err_u = 1'b0;
    chk_out("t4.he+3", 1'b1, 1'b1, 1'b0, 2'd0);
    link_if.channel_up_u = 1'b0;
    step(4);
    chk_retry("t4", 8'd3);

    // 5. reinit_req coincident with synced channel_up in WAIT_LINK.
    step(12);
    chk_out("t5.pma", 1'b1, 1'b0, 1'b0, 2'd1);
    step(4);
    chk_out("t5.wait", 1'b0, 1'b0, 1'b0, 2'd2);
    link_if.channel_up_u = 1'b1;
    step(2);
    link_if.reinit_req = 1'b1;
    step(1);
    link_if.reinit_req = 1'b0;
    chk_out("t5.reinit", 1'b1, 1'b1, 1'b0, 2'd0);
    chk_retry("t5", 8'd4);
    // reinit_req inside RESET_HOLD must not disturb the hold count.
    step(5);
    link_if.reinit_req = 1'b1;
    step(1);
    link_if.reinit_req = 1'b0;
    step(9);
    chk_out("t5.e15", 1'b1, 1'b1, 1'b0, 2'd0);
    step(1);
    chk_out("t5.e16", 1'b1, 1'b0, 1'b0, 2'd1);
    chk_retry("t5.hold", 8'd4);
    step(5);
    chk_out("t5.up", 1'b0, 1'b0, 1'b1, 2'd3);

    // 6. Asynchronous reset mid-PMA_RELEASE.
    link_if.reinit_req = 1'b1;
    step(1);
    link_if.reinit_req   = 1'b0;
    link_if.channel_up_u = 1'b0;
    chk_retry("t6.pre", 8'd5);
    step(16);
    step(2);
    chk_out("t6.pma", 1'b1, 1'b0, 1'b0, 2'd1);
    #2;
    ap_rst_n_i = 1'b0;
    #1;
    chk_out("t6.async", 1'b1, 1'b1, 1'b0, 2'd0);
    chk_retry("t6.async", 8'd0);
    step(1);
    ap_rst_n_i = 1'b1;

    // 300 forced retries from PMA_RELEASE saturate the retry counter.
    for (int i = 0; i < 300; i++) begin
      step(16);
      link_if.reinit_req = 1'b1;
      step(1);
      link_if.reinit_req = 1'b0;
    end
    chk_out("t6.sat", 1'b1, 1'b1, 1'b0, 2'd0);
    chk_retry("t6.sat", 8'hFF);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_aurora_link_reset_ctrl
`default_nettype wire
